systolic_edge_feeder: RTL and testbench
=======================================

Name: systolic_edge_feeder

Overview:
- Transmit side of the PE edge protocol: drives the left edge of an N-row PE array, which the PEs receive as a_left/enleft/cmleft.
- Accepts one K-column burst of A over a valid/ready handshake and skews it so row i sees column k exactly i cycles after row 0.
- Flags the first and last column of the burst so PEs know when to restart and when to stop accumulating.
- Sits between the tile buffer read port and PE[i][0] of every row.

Parameters:
- N, 8, number of PE rows (lanes); N>=1
- MAX_K, 256, maximum burst length in columns

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle burst request; sampled only in IDLE
- k_len  in  $clog2(MAX_K+1)  burst length; sampled with start
- type_in  in  params::full_type_t  compute type; latched at start
- in_valid  in  1  column valid
- in_ready  out  1  feeder accepts a column
- in_col  in  32*N  column k; row i in bits [32i+31:32i]
- a_out  out  32*N  per-row data to a_left
- en_out  out  N  per-row enable to enleft
- cm_out  out  N  per-row first-column (restart) flag to cmleft
- compute_type_out  out  params::full_type_t  latched type, constant while busy
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on the final column at row N-1

Behaviour:
- FSM states: IDLE, STREAM, DRAIN (encoding is params::feeder_state_t).
- IDLE:
  - in_ready=0.
  - start with k_len>0: latch k_len and type_in, clear the column counter, go to STREAM.
  - start with k_len==0: done=1 the next cycle, stay in IDLE.
  - start is ignored in every state other than IDLE.
- STREAM:
  - in_ready=1.
  - Accept when in_valid&&in_ready. The accepted column enters lane 0 with en=1, first=(count==0), last=(count==k_len-1).
  - Cycle without in_valid: a bubble enters lane 0 (en=0, first=0, last=0, data held at its previous value). Bubbles are legal mid-burst.
  - Accepting the column with last=1 moves the FSM to DRAIN.
- DRAIN:
  - in_ready=0; bubbles enter lane 0.
  - When the last flag reaches the output of lane N-1: done=1 and the FSM returns to IDLE in that same cycle.
  - N==1: done is asserted 1 cycle after the last acceptance.
- Skew and latency:
  - Lane i is a register chain of depth i+1, so a column accepted at cycle T appears on row i at T+1+i.
  - en, first and last travel alongside the data; a_out[i], en_out[i] and cm_out[i] are all registered.
- Bursts back-to-back: start is accepted in the IDLE cycle after done. Lanes then still hold only bubbles, so output bubbles are allowed to overlap.
- compute_type_out:
  - Updates only on an accepted start.
  - Holds its value after done until the next accepted start.
- Reset (including mid-burst):
  - Every output goes to 0: a_out, en_out, cm_out, done, busy, in_ready, compute_type_out.
  - All lane registers and the counter are cleared; the FSM goes to IDLE.
  - Data in flight is discarded; no done pulse is produced.
- Width rules:
  - The column counter is $clog2(MAX_K+1) bits.
  - k_len>MAX_K is clamped to MAX_K.

Optional Feature:
- Macro: FEEDER_BUBBLE_CNT_EN.
- Enabled:
  - Adds an output port bubble_cnt, 16 bits, counting STREAM cycles with in_valid=0.
  - The counter clears on an accepted start, saturates at 16'hFFFF, resets to 0 and holds its value after done.
- Disabled: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package params additions:
  - feeder_state_t (IDLE/STREAM/DRAIN).
  - feeder_lane_t struct {data[31:0], en, first, last}.
  - FEEDER_MAX_K constant.
- Sub-module skew_lane:
  - Parameter DEPTH; carries a feeder_lane_t through DEPTH registers with synchronous reset.
  - Instantiated N times in a generate loop with DEPTH=i+1.

Test Plan:
- Basic skew (N=4, start, k_len=3, columns 0x10..,0x20..,0x30.., in_valid held high):
  - Row i sees en=1 at cycles T+1+i..T+3+i.
  - cm_out[i]=1 only on column 0x10.
  - done at T+2+4=T+6.
- Bubble mid-burst (in_valid low for 2 cycles between columns 1 and 2):
  - en_out shows a 2-cycle gap on every row, skewed by i.
  - done is delayed by 2 cycles.
  - bubble_cnt=2 when the macro is on.
- k_len=0: done pulses 1 cycle after start; busy and in_ready stay 0; en_out stays 0.
- Reset mid-burst after column 1 of 4: the next cycle all outputs are 0 and the FSM is IDLE; a fresh start with k_len=2 completes normally.
- start asserted while busy, with a different type_in: ignored; compute_type_out unchanged; burst length unchanged.
- Back-to-back bursts (start in the cycle after done, k_len=1 twice): two done pulses spaced N+2 cycles apart; cm_out set on both first columns.

Source files
------------

// File: rtl/systolic_edge_feeder_pkg.sv
// Shared types for the PE-array left-edge feeder: FSM encoding, lane payload, limits.
// Optional feature macro (used by the interface and top): FEEDER_BUBBLE_CNT_EN.
package systolic_edge_feeder_pkg;

  localparam int FEEDER_MAX_K = 256;

  typedef logic [3:0] full_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        en;
    logic        first;
    logic        last;
  } feeder_lane_t;

  function automatic int feeder_kw(input int max_k);
    return $clog2(max_k + 1);
  endfunction

endpackage

// File: rtl/systolic_edge_feeder_if.sv
// Burst request, column handshake and skewed PE-edge outputs of the feeder.
// FEEDER_BUBBLE_CNT_EN adds the bubble_cnt observation port.
interface systolic_edge_feeder_if
  import systolic_edge_feeder_pkg::*;
#(
  parameter int N     = 8,
  parameter int MAX_K = FEEDER_MAX_K
);
  localparam int KW = feeder_kw(MAX_K);

  logic             start;
  logic [KW-1:0]    k_len;
  full_type_t       type_in;
  logic             in_valid;
  logic             in_ready;
  logic [32*N-1:0]  in_col;
  logic [32*N-1:0]  a_out;
  logic [N-1:0]     en_out;
  logic [N-1:0]     cm_out;
  full_type_t       compute_type_out;
  logic             busy;
  logic             done;
`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0]      bubble_cnt;
`endif

  modport slave (
    input  start, k_len, type_in, in_valid, in_col,
    output in_ready, a_out, en_out, cm_out, compute_type_out, busy, done
`ifdef FEEDER_BUBBLE_CNT_EN
    , output bubble_cnt
`endif
  );

  modport master (
    output start, k_len, type_in, in_valid, in_col,
    input  in_ready, a_out, en_out, cm_out, compute_type_out, busy, done
`ifdef FEEDER_BUBBLE_CNT_EN
    , input bubble_cnt
`endif
  );

endinterface

// File: rtl/systolic_edge_feeder_skew_lane.sv
// One row of the skew: a DEPTH-stage shift register carrying data plus en/first/last.
module skew_lane
  import systolic_edge_feeder_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  feeder_lane_t d,
  output feeder_lane_t q
);

  feeder_lane_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        stage_q[j] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int j = 1; j < DEPTH; j++) begin
        stage_q[j] <= stage_q[j-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_edge_feeder.sv
// Accepts one K-column burst and skews it onto the left edge of an N-row PE array.
// Define FEEDER_BUBBLE_CNT_EN to count STREAM cycles without a valid column.
module systolic_edge_feeder
  import systolic_edge_feeder_pkg::*;
#(
  parameter int N     = 8,
  parameter int MAX_K = FEEDER_MAX_K
) (
  input logic                   clk,
  input logic                   rst,
  systolic_edge_feeder_if.slave bus
);

  localparam int KW = feeder_kw(MAX_K);
  localparam logic [KW-1:0] K_MAX = KW'(MAX_K);
  localparam logic [N-1:0]  LAST_ROW = N'(1) << (N - 1);

  feeder_state_t   state_q;
  logic [KW-1:0]   klen_q;
  logic [KW-1:0]   count_q;
  full_type_t      type_q;
  logic            done_zero_q;
  logic [32*N-1:0] hold_q;

  logic            accept;
  logic            is_first;
  logic            is_last;
  logic            drain_hit;
  logic [KW-1:0]   k_eff;

  feeder_lane_t    lane_in  [N];
  feeder_lane_t    lane_out [N];
  logic [32*N-1:0] a_vec;
  logic [N-1:0]    en_vec;
  logic [N-1:0]    cm_vec;
  logic [N-1:0]    last_vec;

  assign k_eff    = (bus.k_len > K_MAX) ? K_MAX : bus.k_len;
  assign accept   = (state_q == STREAM) && bus.in_valid;
  assign is_first = (count_q == '0);
  assign is_last  = (count_q == klen_q - 1'b1);
  // Only one burst is ever in flight, so while draining the last flag can sit on the final row alone.
  assign drain_hit = (state_q == DRAIN) && (last_vec == LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      klen_q      <= '0;
      count_q     <= '0;
      type_q      <= '0;
      done_zero_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      done_zero_q <= 1'b0;
      if (accept) begin
        hold_q <= bus.in_col;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (k_eff == '0) begin
              done_zero_q <= 1'b1;
            end else begin
              klen_q  <= k_eff;
              count_q <= '0;
              type_q  <= bus.type_in;
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            count_q <= count_q + 1'b1;
            if (is_last) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_hit) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      // Bubbles keep the previous column's data so the PE inputs do not toggle needlessly.
      assign lane_in[gi] = '{
        data:  accept ? bus.in_col[32*gi +: 32] : hold_q[32*gi +: 32],
        en:    accept,
        first: accept && is_first,
        last:  accept && is_last
      };

      skew_lane #(
        .DEPTH (gi + 1)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .d   (lane_in[gi]),
        .q   (lane_out[gi])
      );

      assign a_vec[32*gi +: 32] = lane_out[gi].data;
      assign en_vec[gi]         = lane_out[gi].en;
      assign cm_vec[gi]         = lane_out[gi].first;
      assign last_vec[gi]       = lane_out[gi].last;
    end
  endgenerate

  assign bus.a_out            = a_vec;
  assign bus.en_out           = en_vec;
  assign bus.cm_out           = cm_vec;
  assign bus.compute_type_out = type_q;
  assign bus.busy             = (state_q != IDLE);
  assign bus.in_ready         = (state_q == STREAM);
  assign bus.done             = done_zero_q | drain_hit;

`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if ((state_q == IDLE) && bus.start) begin
      bubble_cnt_q <= '0;
    end else if ((state_q == STREAM) && !bus.in_valid && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Randomized bench for systolic_edge_feeder: a per-cycle schedule of expected edge
// events is built from the burst plan and compared on every falling clock edge.
module tb_systolic_edge_feeder;

  localparam int N     = 4;
  localparam int MAX_K = 16;
  localparam int KW    = $clog2(MAX_K + 1);
  localparam int HORIZON = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_edge_feeder_if #(.N(N), .MAX_K(MAX_K)) bus ();

  systolic_edge_feeder #(.N(N), .MAX_K(MAX_K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Expected schedule, indexed by cycle number.
  logic [N-1:0]    m_en   [HORIZON];
  logic [N-1:0]    m_cm   [HORIZON];
  logic [32*N-1:0] m_dat  [HORIZON];
  logic            m_done [HORIZON];
  logic            m_rdy  [HORIZON];
  logic            m_busy [HORIZON];
  logic [3:0]      m_type;
  int              m_bub;

  int cyc;
  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    chk("en_out", bus.en_out, m_en[cyc]);
    chk("cm_out", bus.cm_out, m_cm[cyc]);
    chk("done", bus.done, m_done[cyc]);
    chk("in_ready", bus.in_ready, m_rdy[cyc]);
    chk("busy", bus.busy, m_busy[cyc]);
    chk("compute_type_out", bus.compute_type_out, m_type);
    for (int i = 0; i < N; i++) begin
      if (m_en[cyc][i]) begin
        chk($sformatf("a_out_row%0d", i), bus.a_out[32*i +: 32], m_dat[cyc][32*i +: 32]);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= HORIZON - 64) begin
      $display("FAIL cycle_budget: observed cycle %0d required below %0d", cyc, HORIZON - 64);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  function automatic logic [32*N-1:0] rand_col();
    logic [32*N-1:0] c;
    for (int i = 0; i < N; i++) c[32*i +: 32] = $urandom;
    return c;
  endfunction

  // A column accepted in cycle t reaches row i in cycle t+1+i.
  task automatic rec_accept(input int t, input logic [32*N-1:0] col, input bit first);
    for (int i = 0; i < N; i++) begin
      m_en[t+1+i][i]              = 1'b1;
      m_cm[t+1+i][i]              = first;
      m_dat[t+1+i][32*i +: 32]    = col[32*i +: 32];
    end
  endtask

  task automatic check_bubbles(input string tag);
`ifdef FEEDER_BUBBLE_CNT_EN
    chk(tag, bus.bubble_cnt, m_bub);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic burst(input int klen, input logic [3:0] ty, input int gap_after,
                       input int gap_len, input bit rnd_bub, input bit noise);
    int keff, t, t_last, acc, gap_left, d;
    bit v;
    logic [32*N-1:0] col;
    keff = (klen > MAX_K) ? MAX_K : klen;
    bus.start   = 1'b1;
    bus.k_len   = KW'(klen);
    bus.type_in = ty;
    if (keff == 0) begin
      m_done[cyc+1] = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      return;
    end
    tick();
    bus.start = 1'b0;
    m_type = ty;
    m_bub = 0;
    acc = 0;
    gap_left = 0;
    t_last = cyc;
    while (acc < keff) begin
      t = cyc;
      v = rnd_bub ? ($urandom_range(0, 3) != 0) : (gap_left == 0);
      col = rand_col();
      bus.in_valid = v;
      bus.in_col   = col;
      if (noise) begin
        bus.start   = $urandom_range(0, 1);
        bus.k_len   = KW'($urandom);
        bus.type_in = ~ty;
      end
      m_rdy[t]  = 1'b1;
      m_busy[t] = 1'b1;
      if (v) begin
        rec_accept(t, col, acc == 0);
        if (acc == gap_after) gap_left = gap_len;
        t_last = t;
        acc++;
      end else begin
        m_bub++;
        if (gap_left > 0) gap_left--;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    d = t_last + N;
    m_done[d] = 1'b1;
    while (cyc <= d) begin
      m_busy[cyc] = 1'b1;
      if (noise) begin
        bus.start = $urandom_range(0, 1);
        bus.k_len = KW'($urandom);
      end
      tick();
    end
    bus.start   = 1'b0;
    bus.type_in = ty;
    check_bubbles("bubble_cnt");
  endtask

  initial begin : stim
    int r;
    logic [32*N-1:0] col;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    m_type = '0;
    m_bub = 0;
    for (int i = 0; i < HORIZON; i++) begin
      m_en[i] = '0; m_cm[i] = '0; m_dat[i] = '0;
      m_done[i] = 1'b0; m_rdy[i] = 1'b0; m_busy[i] = 1'b0;
    end
    bus.start = 1'b0; bus.k_len = '0; bus.type_in = '0;
    bus.in_valid = 1'b0; bus.in_col = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    chk("a_out_reset", bus.a_out, '0);
    check_bubbles("bubble_cnt_reset");
    repeat (3) tick();

    // Basic skew, then a two-cycle gap between columns 1 and 2.
    burst(3, 4'h3, -1, 0, 1'b0, 1'b0);
    burst(4, 4'h5, 1, 2, 1'b0, 1'b0);

    // Zero-length burst: a lone done pulse, nothing streamed.
    burst(0, m_type, -1, 0, 1'b0, 1'b0);
    tick();

    // Reset after two of four columns have been accepted.
    bus.start = 1'b1; bus.k_len = KW'(4); bus.type_in = 4'h9;
    tick();
    bus.start = 1'b0;
    m_type = 4'h9;
    for (int c = 0; c < 2; c++) begin
      col = rand_col();
      bus.in_valid = 1'b1;
      bus.in_col = col;
      m_rdy[cyc] = 1'b1;
      m_busy[cyc] = 1'b1;
      rec_accept(cyc, col, c == 0);
      tick();
    end
    r = cyc;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    m_rdy[r] = 1'b1;
    m_busy[r] = 1'b1;
    for (int i = r + 1; i < r + 64; i++) begin
      m_en[i] = '0; m_cm[i] = '0; m_done[i] = 1'b0; m_rdy[i] = 1'b0; m_busy[i] = 1'b0;
    end
    tick();
    rst = 1'b0;
    m_type = '0;
    m_bub = 0;
    chk("a_out_after_rst", bus.a_out, '0);
    check_bubbles("bubble_cnt_after_rst");
    tick();
    burst(2, 4'h7, -1, 0, 1'b0, 1'b0);

    // Start pulses and other types while busy must be ignored.
    burst(5, 4'hA, -1, 0, 1'b0, 1'b1);

    // Back-to-back single-column bursts.
    burst(1, 4'h2, -1, 0, 1'b0, 1'b0);
    burst(1, 4'h4, -1, 0, 1'b0, 1'b0);

    // Over-long request is clamped to MAX_K columns.
    burst(MAX_K + 4, 4'h6, -1, 0, 1'b1, 1'b0);

    for (int b = 0; b < 10; b++) begin
      burst($urandom_range(0, MAX_K + 2), 4'($urandom_range(1, 15)), -1, 0, 1'b1,
            1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (N + 2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
